dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-side memory responder for the single-cycle ARM core. It sits at the far end of the core's data bus: MemWrite, be, ALUResult (address) and WriteData come in; ReadData goes out.
- Provides byte-lane-enabled word RAM plus a small MMIO register window.
- Flags illegal byte-enable patterns and unmapped addresses.
- Reads are combinational, because the core is single-cycle. All state updates happen on the rising clock edge.

Parameters:
- DEPTH, 64, number of 32-bit RAM words (power of two, at most 1024).
- MMIO_BASE, 32'h0000_1000, base address of the 16-byte MMIO window (16-byte aligned).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write strobe (core MemWrite).
- be  in  4  byte-lane enables; bit i selects bits [8i+7:8i].
- a  in  32  byte address (core ALUResult).
- wd  in  32  write data (core WriteData), already lane-aligned by the core.
- rd  out  32  read data, full word, combinational.
- err  out  1  combinational access-error flag for the current cycle.
- err_sticky  out  1  registered; set by any error, cleared only by reset.
- led  out  8  MMIO LED register.

Behaviour:
- Clocking and reset: one clock domain. On reset assertion, asynchronously:
  - led=0, err_sticky=0, CYCLE=0, STORES=0, SCRATCH=0.
  - The RAM array is not reset; unwritten words read X.
- Address decode (word index = a[11:2]; a[1:0] ignored for indexing):
  - RAM hit: a[31:12]==0 and a[11:2] < DEPTH.
  - MMIO hit: a[31:4]==MMIO_BASE[31:4]; register offset = a[3:2].
  - Otherwise unmapped.
- Legal be patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- err=1 when any of the following holds:
  - we=1 and be is not a legal pattern;
  - the access is unmapped (we=0 or we=1), gated only when we=1 or be!=0;
  - an MMIO write violates its register rule (listed below).
  - err is 0 in all other cases.
- Any write that raises err is fully suppressed: no lane changes and no counter increments.
- RAM write: on posedge with we=1, RAM hit and err=0, only enabled lanes are written. Other lanes keep their value.
- Read:
  - rd always returns the full addressed word regardless of be.
  - RAM hit gives the array word; MMIO hit gives the register value.
  - Unmapped returns 32'h0.
  - A read in the same cycle as a write to the same word returns the old value; the new value is visible next cycle.
- MMIO registers (offset: name, access):
  - 0x0 LED: RW, bits[7:0]. Writes require be[0]=1 and update led from wd[7:0]. Other lanes are ignored. be[0]=0 counts as a violation. Reads return {24'h0, led}.
  - 0x4 CYCLE: free-running 32-bit counter, +1 every clock, wraps FFFF_FFFF to 0. A write with be=1111 loads wd, and that load takes priority over the increment for that edge. Any other be is a violation.
  - 0x8 STORES: read-only. 16-bit saturating count of accepted RAM writes (sticks at FFFF). Reads return {16'h0, STORES}. Any write is a violation.
  - 0xC SCRATCH: 32-bit RW with per-lane enables, same rules as RAM.
- err_sticky <= err_sticky | err on each posedge.
- Reset asserted mid-cycle: registers clear immediately, and no write completes on the edge while reset is high.
- Latency: read is 0 cycles (combinational). A write is visible on the cycle after its edge.

Test Plan:
1. RAM byte lanes:
   - Write 32'hDEADBEEF to 0x10 with be=1111, then write wd=32'h0000_AA00 with be=0010.
   - Next cycle rd@0x10 = 32'hDEADAAEF. STORES=2. err stays 0.
2. Illegal be and unmapped accesses:
   - Write be=0101 to 0x20: RAM unchanged, err=1 that cycle, err_sticky=1 afterwards, STORES unchanged.
   - Read 0x8000_0000: rd=0, err=1.
3. CYCLE counter:
   - Release reset and read 0x1004 after 10 clocks: value 10.
   - Write 32'hFFFF_FFFE with be=1111: reads FFFF_FFFE, then FFFF_FFFF, then 0000_0000 on successive cycles.
   - Write with be=0011: err=1, count continues.
4. LED and SCRATCH:
   - Write 0x1000 wd=32'h1234_5678 be=0001: led=8'h78, rd=32'h0000_0078.
   - Write 0x1000 be=0010: err=1, led unchanged.
   - SCRATCH be=1100 write of 32'hABCD_0000 over 0: rd=32'hABCD_0000.
5. STORES saturation:
   - Perform 65,537 accepted RAM writes: STORES reads 16'hFFFF.
   - A write to 0x1008: err=1.
6. Asynchronous reset mid-write:
   - Assert reset between edges while we=1 targets LED: led=0 immediately, the write is not applied at the next edge, and CYCLE, STORES and err_sticky are all 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM plus a 16-byte MMIO window (LED, CYCLE, STORES, SCRATCH).
// Latency: reads are combinational (0 cycles); writes land on the rising edge and are visible next cycle.
// Backpressure: none, every access completes in its own cycle; illegal accesses raise err and are dropped.
module dmem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        err,
    output logic        err_sticky,
    output logic [7:0]  led
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    localparam logic [1:0] OFF_LED     = 2'd0;
    localparam logic [1:0] OFF_CYCLE   = 2'd1;
    localparam logic [1:0] OFF_STORES  = 2'd2;
    localparam logic [1:0] OFF_SCRATCH = 2'd3;

    logic [31:0] mem [DEPTH];
    logic [31:0] cycle_cnt;
    logic [31:0] scratch;
    logic [15:0] stores;

    logic          ram_hit;
    logic          mmio_hit;
    logic [1:0]    reg_off;
    logic [AW-1:0] widx;
    logic          be_legal;
    logic          mmio_viol;
    logic          access;
    logic          ram_wr;
    logic          mmio_wr;
    logic          unused_addr;

    assign ram_hit     = (a[31:12] == 20'h0) && ({1'b0, a[11:2]} < DEPTH_W);
    assign mmio_hit    = (a[31:4] == MMIO_BASE[31:4]);
    assign reg_off     = a[3:2];
    assign widx        = a[AW+1:2];
    assign access      = we || (be != 4'h0);
    assign unused_addr = ^a[1:0];

    always_comb begin
        be_legal = 1'b0;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end

    always_comb begin
        mmio_viol = 1'b0;
        if (we && mmio_hit) begin
            case (reg_off)
                OFF_LED:    mmio_viol = !be[0];
                OFF_CYCLE:  mmio_viol = (be != 4'hF);
                OFF_STORES: mmio_viol = 1'b1;
                default:    mmio_viol = 1'b0;
            endcase
        end
    end

    // An idle bus (we=0, be=0) may carry any address without flagging it.
    assign err = (we && !be_legal)
               || (access && !ram_hit && !mmio_hit)
               || mmio_viol;

    assign ram_wr  = we && !err && ram_hit;
    assign mmio_wr = we && !err && mmio_hit;

    always_comb begin
        rd = 32'h0;
        if (ram_hit) begin
            rd = mem[widx];
        end else if (mmio_hit) begin
            case (reg_off)
                OFF_LED:    rd = {24'h0, led};
                OFF_CYCLE:  rd = cycle_cnt;
                OFF_STORES: rd = {16'h0, stores};
                default:    rd = scratch;
            endcase
        end
    end

    // The array has no reset; reset still blocks a write landing on an edge it overlaps.
    always_ff @(posedge clk) begin
        if (ram_wr && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led        <= 8'h0;
            err_sticky <= 1'b0;
            cycle_cnt  <= 32'h0;
            stores     <= 16'h0;
            scratch    <= 32'h0;
        end else begin
            err_sticky <= err_sticky | err;

            if (mmio_wr && reg_off == OFF_CYCLE) begin
                cycle_cnt <= wd;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            if (mmio_wr && reg_off == OFF_LED) begin
                led <= wd[7:0];
            end

            if (mmio_wr && reg_off == OFF_SCRATCH) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        scratch[8*i +: 8] <= wd[8*i +: 8];
                    end
                end
            end

            if (ram_wr && stores != 16'hFFFF) begin
                stores <= stores + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table plus hand-written CYCLE, saturation and reset sequences.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  be;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    logic        err_sticky;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
        logic [7:0]  led;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
        logic [7:0]  led;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];

    dmem_responder #(.DEPTH(64), .MMIO_BASE(32'h0000_1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .be         (be),
        .a          (a),
        .wd         (wd),
        .rd         (rd),
        .err        (err),
        .err_sticky (err_sticky),
        .led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one bus cycle at the falling edge and compares just before the rising edge.
    task automatic apply(input logic w, input logic [3:0] b, input logic [31:0] ad,
                         input logic [31:0] d, input logic [31:0] erd, input logic eerr,
                         input logic chk, input logic [7:0] eled, input string nm);
        exp_t e;
        @(negedge clk);
        we = w; be = b; a = ad; wd = d;
        e.rd = erd; e.err = eerr; e.chk_rd = chk; e.led = eled;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            if (e.chk_rd) check32({nm, ".rd"}, rd, e.rd);
            check32({nm, ".err"}, {31'h0, err}, {31'h0, e.err});
            check32({nm, ".led"}, {24'h0, led}, {24'h0, e.led});
        end
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; be = 4'h0; a = 32'h0; wd = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        apply(0, 4'hF, 32'h1004, 0, 32'h0, 0, 1, 8'h00, "rst.cycle");
        apply(0, 4'hF, 32'h1008, 0, 32'h0, 0, 1, 8'h00, "rst.stores");
        apply(0, 4'hF, 32'h100C, 0, 32'h0, 0, 1, 8'h00, "rst.scratch");
        check32("rst.err_sticky", {31'h0, err_sticky}, 32'h0);
        reset = 1'b0;

        // CYCLE counts edges since reset release
        a = 32'h1004;
        repeat (10) @(posedge clk);
        apply(0, 4'hF, 32'h1004, 0,            32'd10,       0, 1, 8'h00, "cyc.ten");
        apply(1, 4'hF, 32'h1004, 32'hFFFF_FFFE, 32'd11,       0, 1, 8'h00, "cyc.load");
        apply(0, 4'hF, 32'h1004, 0,            32'hFFFF_FFFE, 0, 1, 8'h00, "cyc.fffe");
        apply(0, 4'hF, 32'h1004, 0,            32'hFFFF_FFFF, 0, 1, 8'h00, "cyc.ffff");
        apply(0, 4'hF, 32'h1004, 0,            32'h0,         0, 1, 8'h00, "cyc.wrap");
        check32("cyc.sticky_clear", {31'h0, err_sticky}, 32'h0);
        apply(1, 4'h3, 32'h1004, 32'h5555_5555, 32'd1,        1, 1, 8'h00, "cyc.badbe");
        apply(0, 4'hF, 32'h1004, 0,            32'd2,         0, 1, 8'h00, "cyc.cont");
        check32("cyc.sticky_set", {31'h0, err_sticky}, 32'h1);

        // we, be, a, wd, rd, err, chk_rd, led
        tv.push_back('{1, 4'hF, 32'h10,        32'hDEAD_BEEF, 32'h0,         0, 0, 8'h00});
        tv.push_back('{1, 4'h2, 32'h10,        32'h0000_AA00, 32'hDEAD_BEEF, 0, 1, 8'h00});
        tv.push_back('{0, 4'hF, 32'h10,        32'h0,         32'hDEAD_AAEF, 0, 1, 8'h00});
        tv.push_back('{0, 4'hF, 32'h1008,      32'h0,         32'h2,         0, 1, 8'h00});
        tv.push_back('{1, 4'hF, 32'h20,        32'hCAFE_F00D, 32'h0,         0, 0, 8'h00});
        tv.push_back('{1, 4'h5, 32'h20,        32'h1111_1111, 32'hCAFE_F00D, 1, 1, 8'h00});
        tv.push_back('{0, 4'hF, 32'h20,        32'h0,         32'hCAFE_F00D, 0, 1, 8'h00});
        tv.push_back('{0, 4'hF, 32'h1008,      32'h0,         32'h3,         0, 1, 8'h00});
        tv.push_back('{0, 4'hF, 32'h8000_0000, 32'h0,         32'h0,         1, 1, 8'h00});
        tv.push_back('{0, 4'h0, 32'h8000_0000, 32'h0,         32'h0,         0, 1, 8'h00});
        tv.push_back('{1, 4'h1, 32'h1000,      32'h1234_5678, 32'h0,         0, 1, 8'h00});
        tv.push_back('{0, 4'hF, 32'h1000,      32'h0,         32'h78,        0, 1, 8'h78});
        tv.push_back('{1, 4'h2, 32'h1000,      32'hFFFF_FFFF, 32'h78,        1, 1, 8'h78});
        tv.push_back('{0, 4'hF, 32'h1000,      32'h0,         32'h78,        0, 1, 8'h78});
        tv.push_back('{1, 4'hF, 32'h100C,      32'h0,         32'h0,         0, 1, 8'h78});
        tv.push_back('{1, 4'hC, 32'h100C,      32'hABCD_0000, 32'h0,         0, 1, 8'h78});
        tv.push_back('{0, 4'hF, 32'h100C,      32'h0,         32'hABCD_0000, 0, 1, 8'h78});
        tv.push_back('{1, 4'hF, 32'h1008,      32'h0,         32'h3,         1, 1, 8'h78});
        tv.push_back('{1, 4'h6, 32'h10,        32'h0,         32'hDEAD_AAEF, 1, 1, 8'h78});
        tv.push_back('{1, 4'h3, 32'h1000,      32'h0000_005A, 32'h78,        0, 1, 8'h78});
        tv.push_back('{0, 4'hF, 32'h1000,      32'h0,         32'h5A,        0, 1, 8'h5A});
        tv.push_back('{1, 4'hF, 32'hFC,        32'h0F0F_0F0F, 32'h0,         0, 0, 8'h5A});
        tv.push_back('{0, 4'hF, 32'hFC,        32'h0,         32'h0F0F_0F0F, 0, 1, 8'h5A});
        tv.push_back('{0, 4'hF, 32'h100,       32'h0,         32'h0,         1, 1, 8'h5A});
        tv.push_back('{1, 4'hF, 32'h100,       32'h1,         32'h0,         1, 1, 8'h5A});
        tv.push_back('{0, 4'hF, 32'h1010,      32'h0,         32'h0,         1, 1, 8'h5A});
        tv.push_back('{0, 4'hF, 32'h1008,      32'h0,         32'h4,         0, 1, 8'h5A});
        tv.push_back('{1, 4'h0, 32'h10,        32'hFFFF_FFFF, 32'hDEAD_AAEF, 1, 1, 8'h5A});
        tv.push_back('{0, 4'hF, 32'h10,        32'h0,         32'hDEAD_AAEF, 0, 1, 8'h5A});
        tv.push_back('{1, 4'h3, 32'h100C,      32'h0000_1234, 32'hABCD_0000, 0, 1, 8'h5A});
        tv.push_back('{0, 4'hF, 32'h100C,      32'h0,         32'hABCD_1234, 0, 1, 8'h5A});

        foreach (tv[i]) begin
            apply(tv[i].we, tv[i].be, tv[i].a, tv[i].wd, tv[i].rd, tv[i].err,
                  tv[i].chk_rd, tv[i].led, $sformatf("v%0d", i));
        end

        // STORES saturates at FFFF
        for (int i = 0; i < 65537; i++) begin
            @(negedge clk);
            we = 1'b1; be = 4'hF; a = 32'h40 + 32'((i % 16) * 4); wd = 32'(i);
        end
        apply(0, 4'hF, 32'h1008, 0, 32'h0000_FFFF, 0, 1, 8'h5A, "sat.stores");
        apply(1, 4'hF, 32'h1008, 0, 32'h0000_FFFF, 1, 1, 8'h5A, "sat.wr_ro");
        apply(0, 4'hF, 32'h1000, 0, 32'h5A,        0, 1, 8'h5A, "pre.led");

        // Reset between edges while an LED write is on the bus
        @(negedge clk);
        we = 1'b1; be = 4'h1; a = 32'h1000; wd = 32'h0000_00C3;
        #2 reset = 1'b1;
        #1;
        check32("arst.led_now", {24'h0, led}, 32'h0);
        check32("arst.sticky", {31'h0, err_sticky}, 32'h0);
        @(posedge clk);
        #1;
        check32("arst.led_edge", {24'h0, led}, 32'h0);
        @(negedge clk);
        reset = 1'b0; we = 1'b0; be = 4'hF; a = 32'h1004;
        #1 check32("arst.cycle", rd, 32'h0);
        a = 32'h1008;
        #1 check32("arst.stores", rd, 32'h0);
        a = 32'h10;
        #1 check32("arst.ram_kept", rd, 32'hDEAD_AAEF);
        apply(0, 4'hF, 32'h1000, 0, 32'h0, 0, 1, 8'h00, "arst.led_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
